// File: rtl/ps2_letter_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_letter_decoder_if
//   Bundles the raw PS/2 keyboard pins with the decoded letter outputs of
//   ps2_letter_decoder.
//
//   PS2_CLK       raw keyboard clock pin (asynchronous to CLOCK_50)
//   PS2_DAT       raw keyboard data pin  (asynchronous to CLOCK_50)
//   letter        one-hot letter of the last accepted make code (bit 0 = A)
//   letter_valid  one-cycle strobe, letter updated in the same cycle
//   frame_error   one-cycle strobe on bad start/parity/stop bit or timeout
//   busy          high while a frame is being received
//
//   master: keyboard / stimulus side, drives the pins, observes the outputs
//   slave : decoder side
// ---------------------------------------------------------------------------
interface ps2_letter_decoder_if;
  logic        PS2_CLK;
  logic        PS2_DAT;
  logic [25:0] letter;
  logic        letter_valid;
  logic        frame_error;
  logic        busy;

  modport master (
    output PS2_CLK, PS2_DAT,
    input  letter, letter_valid, frame_error, busy
  );

  modport slave (
    input  PS2_CLK, PS2_DAT,
    output letter, letter_valid, frame_error, busy
  );
endinterface

// File: rtl/ps2_letter_decoder.sv
// ---------------------------------------------------------------------------
// ps2_letter_decoder
//   PS/2 receiver and scan-code decoder feeding the enigma plugboard stage.
//   Synchronizes the raw PS/2 pins, deserializes 11-bit frames (start, 8 data
//   LSB first, odd parity, stop), follows make/break/extended prefixes,
//   suppresses typematic repeats and emits a one-hot letter with a one-cycle
//   strobe.
//
//   Parameters
//     TIMEOUT_CYCLES  CLOCK_50 cycles without a PS2_CLK fall before a partial
//                     frame is abandoned
//   Ports
//     CLOCK_50  system clock, rising edge
//     reset     asynchronous, active-low
//     ps2       ps2_letter_decoder_if.slave (pins in, letter/strobes/busy out)
// ---------------------------------------------------------------------------
module ps2_letter_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  ps2_letter_decoder_if.slave  ps2
);

  localparam int               TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]       CODE_BREAK = 8'hF0;
  localparam logic [7:0]       CODE_EXT   = 8'hE0;

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
  typedef enum logic [1:0] {B_NORMAL, B_BREAK, B_EXT, B_EXT_BREAK} byte_state_t;

  // Scan code set 2 to one-hot letter; zero for anything that is not A..Z.
  function automatic logic [25:0] scan_to_letter(input logic [7:0] code);
    logic [25:0] oh;
    oh = '0;
    case (code)
      8'h1C: oh[0]  = 1'b1;  8'h32: oh[1]  = 1'b1;  8'h21: oh[2]  = 1'b1;
      8'h23: oh[3]  = 1'b1;  8'h24: oh[4]  = 1'b1;  8'h2B: oh[5]  = 1'b1;
      8'h34: oh[6]  = 1'b1;  8'h33: oh[7]  = 1'b1;  8'h43: oh[8]  = 1'b1;
      8'h3B: oh[9]  = 1'b1;  8'h42: oh[10] = 1'b1;  8'h4B: oh[11] = 1'b1;
      8'h3A: oh[12] = 1'b1;  8'h31: oh[13] = 1'b1;  8'h44: oh[14] = 1'b1;
      8'h4D: oh[15] = 1'b1;  8'h15: oh[16] = 1'b1;  8'h2D: oh[17] = 1'b1;
      8'h1B: oh[18] = 1'b1;  8'h2C: oh[19] = 1'b1;  8'h3C: oh[20] = 1'b1;
      8'h2A: oh[21] = 1'b1;  8'h1D: oh[22] = 1'b1;  8'h22: oh[23] = 1'b1;
      8'h35: oh[24] = 1'b1;  8'h1A: oh[25] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2: previous synchronized clock.
  // Reset to the idle-high bus level so deassertion never fakes a fall.
  logic clk_p0, clk_p1, clk_p2;
  logic dat_p0, dat_p1;
  logic ps2_fall;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      clk_p2 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2.PS2_CLK;
      clk_p1 <= clk_p0;
      clk_p2 <= clk_p1;
      dat_p0 <= ps2.PS2_DAT;
      dat_p1 <= dat_p0;
    end
  end

  assign ps2_fall = clk_p2 & ~clk_p1;

  // Frame FSM: consumes synchronized falls, produces accepted bytes.
  frame_state_t           frame_state, frame_next;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_p1;
  logic                   parity_p1;
  logic [TMO_W-1:0]       tmo_cnt;
  logic                   start_err, stop_ok, stop_err, tmo_abort;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) frame_state <= F_IDLE;
    else        frame_state <= frame_next;
  end

  always_comb begin
    frame_next = frame_state;
    start_err  = 1'b0;
    stop_ok    = 1'b0;
    stop_err   = 1'b0;
    // A fall in the same cycle restarts the count, so it wins over the abort.
    tmo_abort  = (frame_state != F_IDLE) && !ps2_fall && (tmo_cnt == TMO_LIMIT);
    case (frame_state)
      F_IDLE: begin
        if (ps2_fall) begin
          if (!dat_p1) frame_next = F_DATA;
          else         start_err  = 1'b1;
        end
      end
      F_DATA: begin
        if (ps2_fall && (bit_cnt == 3'd7)) frame_next = F_PARITY;
      end
      F_PARITY: begin
        if (ps2_fall) frame_next = F_STOP;
      end
      F_STOP: begin
        if (ps2_fall) begin
          frame_next = F_IDLE;
          // Odd parity: data bits plus parity bit carry an odd number of ones.
          if (dat_p1 && (^{shift_p1, parity_p1})) stop_ok  = 1'b1;
          else                                     stop_err = 1'b1;
        end
      end
      default: frame_next = F_IDLE;
    endcase
    if (tmo_abort) frame_next = F_IDLE;
  end

  // Stage p1: accepted byte with its valid, plus the frame_error strobe.
  logic       byte_vld_p1;
  logic [7:0] byte_p1;
  logic       frame_error_p1;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      bit_cnt        <= '0;
      shift_p1       <= '0;
      parity_p1      <= 1'b0;
      tmo_cnt        <= '0;
      byte_vld_p1    <= 1'b0;
      byte_p1        <= '0;
      frame_error_p1 <= 1'b0;
    end else begin
      if (frame_state == F_IDLE) bit_cnt <= '0;
      if (ps2_fall && (frame_state == F_DATA)) begin
        shift_p1 <= {dat_p1, shift_p1[7:1]};
        bit_cnt  <= bit_cnt + 3'd1;
      end
      if (ps2_fall && (frame_state == F_PARITY)) parity_p1 <= dat_p1;

      if (ps2_fall || (frame_state == F_IDLE) || tmo_abort) tmo_cnt <= '0;
      else                                                  tmo_cnt <= tmo_cnt + TMO_W'(1);

      byte_vld_p1 <= stop_ok;
      if (stop_ok) byte_p1 <= shift_p1;
      frame_error_p1 <= start_err | stop_err | tmo_abort;
    end
  end

  // Byte FSM: prefix tracking and typematic suppression on accepted bytes.
  byte_state_t byte_state, byte_next;
  logic [7:0]  held_code, held_next;
  logic [25:0] code_letter;
  logic        emit;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) byte_state <= B_NORMAL;
    else        byte_state <= byte_next;
  end

  always_comb begin
    byte_next   = byte_state;
    held_next   = held_code;
    emit        = 1'b0;
    code_letter = scan_to_letter(byte_p1);
    if (byte_vld_p1) begin
      case (byte_state)
        B_NORMAL: begin
          if (byte_p1 == CODE_BREAK)    byte_next = B_BREAK;
          else if (byte_p1 == CODE_EXT) byte_next = B_EXT;
          else if ((code_letter != '0) && (byte_p1 != held_code)) begin
            emit      = 1'b1;
            held_next = byte_p1;
          end
        end
        B_BREAK: begin
          byte_next = B_NORMAL;
          if (byte_p1 == held_code) held_next = '0;
        end
        B_EXT: begin
          byte_next = (byte_p1 == CODE_BREAK) ? B_EXT_BREAK : B_NORMAL;
        end
        B_EXT_BREAK: byte_next = B_NORMAL;
        default:     byte_next = B_NORMAL;
      endcase
    end
  end

  // Stage p2: registered letter outputs.
  logic [25:0] letter_p2;
  logic        vld_p2;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      held_code <= '0;
      letter_p2 <= '0;
      vld_p2    <= 1'b0;
    end else begin
      held_code <= held_next;
      vld_p2    <= emit;
      if (emit) letter_p2 <= code_letter;
    end
  end

  assign ps2.letter       = letter_p2;
  assign ps2.letter_valid = vld_p2;
  assign ps2.frame_error  = frame_error_p1;
  assign ps2.busy         = (frame_state != F_IDLE);

endmodule
